timer_core: RTL and testbench
=============================

# timer_core

Register and counter stage behind the AXI-Lite slave front end of the timer subsystem. It consumes that front end's memory-like request port (enable, write-enable, address, write data) and returns read data with one cycle of latency. It implements a CLINT-style machine timer: one free-running 64-bit `mtime` advanced by an external real-time tick, per-hart `mtimecmp` compare registers driving timer interrupts, and per-hart `msip` software-interrupt bits.

## Interface
- `AXI_ADDR_WIDTH`, default 64: width of `address_i`. Only bits [15:0] are decoded.
- `AXI_DATA_WIDTH`, default 64: width of `data_i` and `data_o`. Must be 64; any other value is illegal.
- `NR_CORES`, default 1: number of harts. Legal range is 1 to 2047.
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, asynchronous and active-high.
- `en_i` in 1: request valid.
- `we_i` in 1: write when high, read when low. Only meaningful while `en_i` is high.
- `address_i` in AXI_ADDR_WIDTH: byte address.
- `data_i` in AXI_DATA_WIDTH: write data. All 64 bits are written; there are no byte strobes.
- `data_o` out AXI_DATA_WIDTH: registered read data.
- `rtc_i` in 1: real-time tick, asynchronous to `clk_i`. Each rising edge increments `mtime` by 1.
- `timer_irq_o` out NR_CORES: bit i is high while `mtime >= mtimecmp[i]`.
- `ipi_o` out NR_CORES: bit i equals `msip[i][0]`.

## Operation
- Address map on `address_i[15:0]`. Upper address bits are ignored.
  - `msip[i]` at 0x0000 + 8·i. Only bit 0 is stored; reads return it zero-extended.
  - `mtimecmp[i]` at 0x4000 + 8·i, 64 bits.
  - `mtime` at 0xBFF8, 64 bits.
  - All other offsets, including hart indices ≥ NR_CORES: reads return 0 and writes are ignored.
- Write: on a clock edge with `en_i && we_i`, the addressed register takes `data_i`.
- Read data path:
  - `data_o` is registered. Each cycle, `data_o <= read_mux(address_i)`.
  - This happens regardless of `en_i` and `we_i`, so data is ready when the front end asserts enable one cycle after presenting the address.
  - Holding the address keeps `data_o` tracking the live register value.
- Tick path:
  - `rtc_i` passes through a two-flop synchronizer (`sync1`, `sync2`) followed by a history flop `rtc_q`.
  - A tick is `sync2 && !rtc_q`.
  - On a tick, `mtime <= mtime + 1`. Arithmetic is modulo 2^64: 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Compare:
  - `timer_irq_o[i] <= (mtime >= mtimecmp[i])`, unsigned 64-bit comparison, registered.
  - The comparison uses the current register values, not the next-state values.
- There is no interrupt acknowledge. Software clears `timer_irq_o[i]` by raising `mtimecmp[i]` or by writing `mtime`.
- Reset values, applied asynchronously on `rst_i`:
  - `mtime` = 0.
  - `mtimecmp[*]` = 0xFFFF_FFFF_FFFF_FFFF.
  - `msip[*]` = 0.
  - `data_o` = 0, `timer_irq_o` = 0, `ipi_o` = 0.
  - Synchronizer flops = 0.
- Reset mid-operation: a write in flight is discarded and a pending tick is lost. Normal operation resumes on the first edge after `rst_i` falls.

## Timing
- Read latency: `address_i` presented at edge n is visible on `data_o` after edge n+1.
- Write visibility:
  - A write at edge n updates the register after edge n.
  - A read of the same address sampled at edge n returns the old value. The new value appears on `data_o` after edge n+1.
- Tick latency: `rtc_i` first sampled high at edge k gives:
  - `sync2` = 1 after edge k+1;
  - `mtime` incremented at edge k+2;
  - `timer_irq_o` updated at edge k+3;
  - `data_o` reading `mtime` shows the new value after edge k+3.
- Only one increment per `rtc_i` rising edge. `rtc_i` must stay high and low for at least 2 `clk_i` cycles each.
- Write to `mtime` and a tick at the same edge: the write wins and the tick is dropped.
- Write to `mtimecmp[i]` at edge n: `timer_irq_o[i]` reflects the new compare value after edge n+1.
- Write to `msip[i]` at edge n: `ipi_o[i]` changes after edge n, since it is driven combinationally from the flop.
- `en_i` high with `we_i` low has no side effects.

## Test plan
- Reset check: assert `rst_i` asynchronously mid-cycle, then release. Required: all outputs are 0 immediately; reading 0x4000 returns 0xFFFF_FFFF_FFFF_FFFF; reading 0xBFF8 returns 0.
- Tick counting: apply 5 `rtc_i` pulses, each 4 cycles high and 4 cycles low. Required: `mtime` reads 5, and each increment lands exactly 2 edges after `rtc_i` is first sampled high.
- Timer interrupt: write `mtimecmp[0]` = 3, then apply ticks. Required: `timer_irq_o[0]` rises one edge after `mtime` becomes 3. Then write `mtimecmp[0]` = 100. Required: `timer_irq_o[0]` falls after edge n+1.
- Wrap and collision:
  - Write `mtime` = 0xFFFF_FFFF_FFFF_FFFF, then apply one tick. Required: `mtime` reads 0.
  - Write `mtime` = 7 on the same edge as a tick. Required: `mtime` reads 7.
- Software interrupt: with NR_CORES=2, write `msip[1]` (0x0008) = 0xFFFF. Required: `ipi_o` = 2'b10 and a read of 0x0008 returns 1. Write 0 to 0x0008. Required: `ipi_o` = 0.
- Unmapped and read-after-write:
  - Write 0xDEAD to 0x0100. Required: a read there returns 0 and no register changes.
  - Read `mtimecmp[0]` on the same edge as a write of 0x55 to it. Required: the first `data_o` is the old value; the next cycle shows 0x55.

Source files
------------

// File: rtl/timer_core.sv
// -----------------------------------------------------------------------------
// timer_core
//
// CLINT-style machine timer that sits behind the AXI-Lite slave front end.
// It holds one free-running 64-bit mtime, a 64-bit mtimecmp per hart that
// drives that hart's timer interrupt, and a one-bit msip per hart that drives
// its software interrupt.
//
// Request port (memory-like, no backpressure):
//   A request is taken on every clock edge where en_i is high. A write
//   (we_i high) commits data_i to the addressed register at that edge. There
//   is no ready signal because every request completes in one cycle. Read
//   data is not gated by en_i: data_o is refreshed from address_i on every
//   edge. The front end therefore presents the address one cycle ahead and
//   finds the data already waiting when it asserts en_i.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous, active-high reset
//   en_i         request valid
//   we_i         1 = write, 0 = read (qualified by en_i)
//   address_i    byte address; only bits [15:0] are decoded
//   data_i       64-bit write data (no byte strobes)
//   data_o       registered read data
//   rtc_i        real-time tick, asynchronous to clk_i
//   timer_irq_o  per-hart timer interrupt (registered mtime >= mtimecmp)
//   ipi_o        per-hart software interrupt (msip bit 0)
//
// Address map on address_i[15:0]:
//   0x0000 + 8*i  msip[i]
//   0x4000 + 8*i  mtimecmp[i]
//   0xBFF8        mtime
//   Anything else reads as 0 and ignores writes.
// -----------------------------------------------------------------------------
module timer_core #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,  // must be 64
    parameter int          NR_CORES       = 1    // 1 .. 2047
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] address_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    input  logic                      rtc_i,
    output logic [NR_CORES-1:0]       timer_irq_o,
    output logic [NR_CORES-1:0]       ipi_o
);

    localparam logic [15:0] MTIME_ADDR = 16'hBFF8;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [15:0] addr;
    logic [10:0] hart_idx;
    logic        aligned;
    logic        msip_sel;
    logic        cmp_sel;
    logic        mtime_sel;
    logic        wr_en;

    // Bits above 15 are ignored by the address map.
    logic        unused_addr_bits;

    assign addr             = address_i[15:0];
    assign unused_addr_bits = ^address_i[AXI_ADDR_WIDTH-1:16];

    // msip occupies 0x0000-0x3FFF and mtimecmp 0x4000-0x7FFF; in both regions
    // the hart number is the doubleword index within the 16 KiB window.
    // mtime at 0xBFF8 lies outside both windows, so the selects never overlap.
    assign hart_idx  = addr[13:3];
    assign aligned   = (addr[2:0] == 3'b000);
    assign msip_sel  = aligned && (addr[15:14] == 2'b00);
    assign cmp_sel   = aligned && (addr[15:14] == 2'b01);
    assign mtime_sel = (addr == MTIME_ADDR);
    assign wr_en     = en_i && we_i;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [63:0]               mtime_q;
    logic [63:0]               mtimecmp_q [NR_CORES];
    logic [NR_CORES-1:0]       msip_q;
    logic [NR_CORES-1:0]       irq_q;
    logic [AXI_DATA_WIDTH-1:0] data_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_d;

    logic sync1_q;
    logic sync2_q;
    logic rtc_q;
    logic tick;

    // -------------------------------------------------------------------------
    // rtc_i synchronizer and rising-edge detect
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            rtc_q   <= 1'b0;
        end else begin
            sync1_q <= rtc_i;
            sync2_q <= sync1_q;
            rtc_q   <= sync2_q;
        end
    end

    assign tick = sync2_q && !rtc_q;

    // -------------------------------------------------------------------------
    // mtime: a software write takes priority over a tick on the same edge.
    // The increment wraps naturally at 2^64.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q <= '0;
        end else if (wr_en && mtime_sel) begin
            mtime_q <= data_i;
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-hart registers. The loop bound doubles as the range check: a hart
    // index >= NR_CORES matches no iteration, so such writes fall away.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_CORES; i++) begin
                mtimecmp_q[i] <= '1;
            end
            msip_q <= '0;
        end else begin
            for (int i = 0; i < NR_CORES; i++) begin
                if (wr_en && cmp_sel && (hart_idx == 11'(i))) begin
                    mtimecmp_q[i] <= data_i;
                end
                if (wr_en && msip_sel && (hart_idx == 11'(i))) begin
                    msip_q[i] <= data_i[0];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Timer interrupts: compare the current register values, so a new
    // mtimecmp or mtime takes one further edge to reach timer_irq_o.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= '0;
        end else begin
            for (int i = 0; i < NR_CORES; i++) begin
                irq_q[i] <= (mtime_q >= mtimecmp_q[i]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path: the mux is sampled every edge, independent of en_i/we_i.
    // A read that coincides with a write to the same register therefore
    // returns the pre-write value.
    // -------------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        if (mtime_sel) begin
            rdata_d = mtime_q;
        end
        for (int i = 0; i < NR_CORES; i++) begin
            if (msip_sel && (hart_idx == 11'(i))) begin
                rdata_d = {63'd0, msip_q[i]};
            end
            if (cmp_sel && (hart_idx == 11'(i))) begin
                rdata_d = mtimecmp_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= rdata_d;
        end
    end

    assign data_o      = data_q;
    assign timer_irq_o = irq_q;
    assign ipi_o       = msip_q;

endmodule

// File: tb/tb_timer_core.sv
// -----------------------------------------------------------------------------
// tb_timer_core
//
// Directed bench for timer_core with two harts. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_timer_core;

    localparam int NR_CORES = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        rtc;
    logic [1:0]  irq;
    logic [1:0]  ipi;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] rd_val;

    timer_core #(
        .AXI_ADDR_WIDTH (64),
        .AXI_DATA_WIDTH (64),
        .NR_CORES       (NR_CORES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .we_i        (we),
        .address_i   (addr),
        .data_i      (wdata),
        .data_o      (rdata),
        .rtc_i       (rtc),
        .timer_irq_o (irq),
        .ipi_o       (ipi)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- tasks
    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One write; returns on the falling edge right after the write edge.
    // The address is left in place so data_o keeps tracking it.
    task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
        addr  = a;
        wdata = d;
        en    = 1'b1;
        we    = 1'b1;
        @(negedge clk);
        en    = 1'b0;
        we    = 1'b0;
    endtask

    // Present the address, let data_o settle for two edges, return it.
    task automatic bus_read(input logic [63:0] a, output logic [63:0] v);
        addr = a;
        en   = 1'b1;
        we   = 1'b0;
        @(negedge clk);
        en   = 1'b0;
        @(negedge clk);
        v = rdata;
    endtask

    // Legal rtc_i pulse: 4 cycles high, 4 cycles low.
    task automatic rtc_pulse();
        rtc = 1'b1;
        repeat (4) @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        rtc   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- Reset: make every output non-zero, then reset mid-cycle.
        bus_write(64'hBFF8, 64'h1234);
        bus_write(64'h0000, 64'h1);
        bus_write(64'h4000, 64'h0);
        addr = 64'hBFF8;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_data_o", rdata, 64'h0);
        check("rst_irq",    {62'd0, irq}, 64'h0);
        check("rst_ipi",    {62'd0, ipi}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(64'h4000, rd_val);
        check("rst_mtimecmp0", rd_val, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_read(64'h4008, rd_val);
        check("rst_mtimecmp1", rd_val, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_read(64'hBFF8, rd_val);
        check("rst_mtime", rd_val, 64'h0);

        // ---- Tick counting with latency: address held on mtime, en low.
        addr = 64'hBFF8;
        for (int p = 0; p < 5; p++) begin
            rtc = 1'b1;
            repeat (3) @(negedge clk);          // edges k, k+1, k+2
            check("tick_before", rdata, 64'(p));
            @(negedge clk);                     // edge k+3
            check("tick_after", rdata, 64'(p + 1));
            rtc = 1'b0;
            repeat (4) @(negedge clk);
        end
        bus_read(64'hBFF8, rd_val);
        check("mtime_five", rd_val, 64'd5);

        // ---- Timer interrupt on hart 0.
        bus_write(64'hBFF8, 64'd0);
        bus_write(64'h4000, 64'd3);
        @(negedge clk);
        check("irq_below", {62'd0, irq}, 64'h0);
        rtc_pulse();
        rtc_pulse();
        rtc = 1'b1;
        repeat (3) @(negedge clk);              // mtime becomes 3 at k+2
        check("irq_not_yet", {62'd0, irq}, 64'h0);
        @(negedge clk);                         // k+3
        check("irq_rise", {62'd0, irq}, 64'h1);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        bus_write(64'h4000, 64'd100);           // edge n
        check("irq_hold_n", {62'd0, irq}, 64'h1);
        @(negedge clk);                         // edge n+1
        check("irq_fall", {62'd0, irq}, 64'h0);

        // ---- Wrap: mtime at all-ones fires both harts, then wraps to 0.
        bus_write(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF);
        check("irq_max_n", {62'd0, irq}, 64'h0);
        @(negedge clk);
        check("irq_max", {62'd0, irq}, 64'h3);
        rtc_pulse();
        bus_read(64'hBFF8, rd_val);
        check("mtime_wrap", rd_val, 64'h0);
        check("irq_after_wrap", {62'd0, irq}, 64'h0);

        // ---- Collision: write mtime on the edge the tick lands (k+2).
        rtc = 1'b1;
        repeat (2) @(negedge clk);              // edges k, k+1
        bus_write(64'hBFF8, 64'd7);             // edge k+2
        repeat (2) @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(64'hBFF8, rd_val);
        check("mtime_collision", rd_val, 64'd7);

        // ---- Software interrupt on hart 1.
        bus_write(64'h0008, 64'hFFFF);
        check("ipi_set", {62'd0, ipi}, 64'h2);
        bus_read(64'h0008, rd_val);
        check("msip1_read", rd_val, 64'h1);
        bus_read(64'h0000, rd_val);
        check("msip0_read", rd_val, 64'h0);
        bus_write(64'h0008, 64'h0);
        check("ipi_clear", {62'd0, ipi}, 64'h0);

        // ---- Unmapped offsets, out-of-range hart, upper address bits.
        bus_write(64'h0100, 64'hDEAD);
        bus_read(64'h0100, rd_val);
        check("unmapped_read", rd_val, 64'h0);
        bus_write(64'h4010, 64'h5);
        bus_read(64'h4010, rd_val);
        check("hart2_cmp_read", rd_val, 64'h0);
        bus_read(64'h4000, rd_val);
        check("cmp0_kept", rd_val, 64'd100);
        bus_read(64'hBFF8, rd_val);
        check("mtime_kept", rd_val, 64'd7);
        bus_read(64'h0000_0001_0000_BFF8, rd_val);
        check("upper_ignored", rd_val, 64'd7);
        check("irq_quiet", {62'd0, irq}, 64'h0);

        // ---- Read and write of mtimecmp[0] on the same edge.
        bus_write(64'h4000, 64'h55);            // edge n
        check("raw_old", rdata, 64'd100);
        @(negedge clk);                         // edge n+1
        check("raw_new", rdata, 64'h55);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
